// File: rtl/xmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : xmem_port_arbiter_if
// Description : Bundle of both requester ports and the x-memory port that
//               the arbiter connects.
// Revision    : 1.0 - initial release
// ============================================================================
interface xmem_port_arbiter_if #(
    parameter int ADDR_LEN = 10,
    parameter int DATA_LEN = 1,
    parameter int SEL_LEN  = 2
);
    logic                r0_req;
    logic [ADDR_LEN-1:0] r0_addr;
    logic [SEL_LEN-1:0]  r0_sel;
    logic                r0_wq;
    logic [DATA_LEN-1:0] r0_wdata;
    logic                r0_gnt;
    logic                r0_rvalid;
    logic [DATA_LEN-1:0] r0_rdata;

    logic                r1_req;
    logic [ADDR_LEN-1:0] r1_addr;
    logic [SEL_LEN-1:0]  r1_sel;
    logic                r1_wq;
    logic [DATA_LEN-1:0] r1_wdata;
    logic                r1_gnt;
    logic                r1_rvalid;
    logic [DATA_LEN-1:0] r1_rdata;

    logic [ADDR_LEN-1:0] mem_addr;
    logic [SEL_LEN-1:0]  mem_sel;
    logic                mem_wq;
    logic [DATA_LEN-1:0] mem_wdata;
    logic [DATA_LEN-1:0] mem_rdata;
    logic                busy;

    // Arbiter side
    modport slave (
        input  r0_req, r0_addr, r0_sel, r0_wq, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_addr, r1_sel, r1_wq, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_addr, mem_sel, mem_wq, mem_wdata,
        input  mem_rdata,
        output busy
    );

    // Requester / memory environment side
    modport master (
        output r0_req, r0_addr, r0_sel, r0_wq, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_addr, r1_sel, r1_wq, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_addr, mem_sel, mem_wq, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/xmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xmem_port_arbiter
// Description : Two-requester round-robin arbiter for the x-memory port with
//               bounded burst locking and read-valid return to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module xmem_port_arbiter #(
    parameter int ADDR_LEN  = 10,
    parameter int DATA_LEN  = 1,
    parameter int SEL_LEN   = 2,
    parameter int MAX_BURST = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    xmem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] burst_cnt_q,  burst_cnt_d;
    logic             last_owner_q, last_owner_d;
    logic             r0_gnt_q,     r0_gnt_d;
    logic             r1_gnt_q,     r1_gnt_d;
    logic             r0_rvalid_q,  r0_rvalid_d;
    logic             r1_rvalid_q,  r1_rvalid_d;
    logic             busy_q,       busy_d;

    logic [ADDR_LEN-1:0] w_mem_addr;
    logic [SEL_LEN-1:0]  w_mem_sel;
    logic [DATA_LEN-1:0] w_mem_wdata;
    logic                w_mem_wq;
    logic                w_xfer0;
    logic                w_xfer1;
    logic                w_burst_full;

    assign w_xfer0      = r0_gnt_q & bus.r0_req;
    assign w_xfer1      = r1_gnt_q & bus.r1_req;
    assign w_burst_full = (burst_cnt_q == C_CNT_MAX);

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.r0_req && bus.r1_req)
                    state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
                else if (bus.r0_req)
                    state_d = ST_OWN0;
                else if (bus.r1_req)
                    state_d = ST_OWN1;
            end
            ST_OWN0: begin
                if (!bus.r0_req)
                    state_d = bus.r1_req ? ST_OWN1 : ST_IDLE;
                else if (bus.r1_req && w_burst_full)
                    state_d = ST_OWN1;
            end
            ST_OWN1: begin
                if (!bus.r1_req)
                    state_d = bus.r0_req ? ST_OWN0 : ST_IDLE;
                else if (bus.r0_req && w_burst_full)
                    state_d = ST_OWN0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter saturates so an uncontested owner keeps the port indefinitely
        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_d == ST_OWN0)
                last_owner_d = 1'b0;
            else if (state_d == ST_OWN1)
                last_owner_d = 1'b1;
        end else if (state_q != ST_IDLE && !w_burst_full) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end

        r0_gnt_d    = (state_d == ST_OWN0);
        r1_gnt_d    = (state_d == ST_OWN1);
        busy_d      = (state_d != ST_IDLE);
        r0_rvalid_d = w_xfer0 & ~bus.r0_wq;
        r1_rvalid_d = w_xfer1 & ~bus.r1_wq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            burst_cnt_q  <= '0;
            last_owner_q <= 1'b1;
            r0_gnt_q     <= 1'b0;
            r1_gnt_q     <= 1'b0;
            r0_rvalid_q  <= 1'b0;
            r1_rvalid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
            r0_gnt_q     <= r0_gnt_d;
            r1_gnt_q     <= r1_gnt_d;
            r0_rvalid_q  <= r0_rvalid_d;
            r1_rvalid_q  <= r1_rvalid_d;
            busy_q       <= busy_d;
        end
    end

    // Write strobe is masked by rst so a write coinciding with reset never lands
    always_comb begin
        w_mem_addr  = '0;
        w_mem_sel   = '0;
        w_mem_wdata = '0;
        w_mem_wq    = 1'b0;
        if (r0_gnt_q) begin
            w_mem_addr  = bus.r0_addr;
            w_mem_sel   = bus.r0_sel;
            w_mem_wdata = bus.r0_wdata;
            w_mem_wq    = bus.r0_wq & w_xfer0 & ~rst;
        end else if (r1_gnt_q) begin
            w_mem_addr  = bus.r1_addr;
            w_mem_sel   = bus.r1_sel;
            w_mem_wdata = bus.r1_wdata;
            w_mem_wq    = bus.r1_wq & w_xfer1 & ~rst;
        end
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_sel   = w_mem_sel;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_wq    = w_mem_wq;

    assign bus.r0_gnt    = r0_gnt_q;
    assign bus.r1_gnt    = r1_gnt_q;
    assign bus.r0_rvalid = r0_rvalid_q;
    assign bus.r1_rvalid = r1_rvalid_q;
    assign bus.r0_rdata  = bus.mem_rdata;
    assign bus.r1_rdata  = bus.mem_rdata;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_xmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xmem_port_arbiter
// Description : Randomized self-checking bench for xmem_port_arbiter against
//               an ownership-level reference model and a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xmem_port_arbiter;

    localparam int ADDR_LEN  = 10;
    localparam int DATA_LEN  = 1;
    localparam int SEL_LEN   = 2;
    localparam int MAX_BURST = 4;
    localparam int N_CYCLES  = 4000;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   err_cnt;

    xmem_port_arbiter_if #(
        .ADDR_LEN (ADDR_LEN),
        .DATA_LEN (DATA_LEN),
        .SEL_LEN  (SEL_LEN)
    ) bus ();

    xmem_port_arbiter #(
        .ADDR_LEN  (ADDR_LEN),
        .DATA_LEN  (DATA_LEN),
        .SEL_LEN   (SEL_LEN),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with one-cycle read latency, driven purely by the DUT's port
    logic [DATA_LEN-1:0] mem_arr [0:(1 << (ADDR_LEN + SEL_LEN)) - 1];
    always @(posedge clk) begin
        if (bus.mem_wq)
            mem_arr[{bus.mem_sel, bus.mem_addr}] <= bus.mem_wdata;
        bus.mem_rdata <= mem_arr[{bus.mem_sel, bus.mem_addr}];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how long it has held it, and
    // the last requester to be granted.
    int                  m_own;
    int                  m_tenure;
    int                  m_last;
    bit                  m_rv [2];
    logic [DATA_LEN-1:0] m_rd;
    logic [DATA_LEN-1:0] m_mem [0:(1 << (ADDR_LEN + SEL_LEN)) - 1];

    task automatic model_reset();
        m_own    = -1;
        m_tenure = 0;
        m_last   = 1;
        m_rv[0]  = 0;
        m_rv[1]  = 0;
    endtask

    task automatic one_cycle();
        bit                  req [2];
        bit                  wq  [2];
        logic [ADDR_LEN-1:0] addr [2];
        logic [SEL_LEN-1:0]  sel  [2];
        logic [DATA_LEN-1:0] wd   [2];
        logic [ADDR_LEN-1:0] e_addr;
        logic [SEL_LEN-1:0]  e_sel;
        logic [DATA_LEN-1:0] e_wd;
        bit                  e_wq;
        int                  nxt;
        int                  oth;

        @(negedge clk);
        if ($urandom_range(7) == 0) bus.r0_req = ~bus.r0_req;
        if ($urandom_range(7) == 0) bus.r1_req = ~bus.r1_req;
        bus.r0_addr  = ADDR_LEN'($urandom_range(15));
        bus.r1_addr  = ADDR_LEN'($urandom_range(15));
        bus.r0_sel   = SEL_LEN'($urandom);
        bus.r1_sel   = SEL_LEN'($urandom);
        bus.r0_wq    = 1'($urandom);
        bus.r1_wq    = 1'($urandom);
        bus.r0_wdata = DATA_LEN'($urandom);
        bus.r1_wdata = DATA_LEN'($urandom);
        rst          = ($urandom_range(99) == 0);
        #1;

        req[0] = bus.r0_req;  req[1] = bus.r1_req;
        wq[0]  = bus.r0_wq;   wq[1]  = bus.r1_wq;
        addr[0] = bus.r0_addr; addr[1] = bus.r1_addr;
        sel[0]  = bus.r0_sel;  sel[1]  = bus.r1_sel;
        wd[0]   = bus.r0_wdata; wd[1]  = bus.r1_wdata;

        check("r0_gnt",    32'(bus.r0_gnt),    32'(m_own == 0));
        check("r1_gnt",    32'(bus.r1_gnt),    32'(m_own == 1));
        check("busy",      32'(bus.busy),      32'(m_own >= 0));
        check("r0_rvalid", 32'(bus.r0_rvalid), 32'(m_rv[0]));
        check("r1_rvalid", 32'(bus.r1_rvalid), 32'(m_rv[1]));
        if (m_rv[0]) check("r0_rdata", 32'(bus.r0_rdata), 32'(m_rd));
        if (m_rv[1]) check("r1_rdata", 32'(bus.r1_rdata), 32'(m_rd));

        if (m_own >= 0) begin
            e_addr = addr[m_own];
            e_sel  = sel[m_own];
            e_wd   = wd[m_own];
            e_wq   = wq[m_own] && req[m_own] && !rst;
        end else begin
            e_addr = '0;
            e_sel  = '0;
            e_wd   = '0;
            e_wq   = 0;
        end
        check("mem_wq",    32'(bus.mem_wq),    32'(e_wq));
        check("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
        check("mem_sel",   32'(bus.mem_sel),   32'(e_sel));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));

        if (rst) begin
            model_reset();
        end else begin
            m_rv[0] = 0;
            m_rv[1] = 0;
            if (m_own >= 0 && req[m_own]) begin
                if (wq[m_own]) begin
                    m_mem[{sel[m_own], addr[m_own]}] = wd[m_own];
                end else begin
                    m_rv[m_own] = 1;
                    m_rd = m_mem[{sel[m_own], addr[m_own]}];
                end
            end
            if (m_own < 0) begin
                if (req[0] && req[1]) nxt = 1 - m_last;
                else if (req[0])      nxt = 0;
                else if (req[1])      nxt = 1;
                else                  nxt = -1;
            end else begin
                oth = 1 - m_own;
                if (!req[m_own])                         nxt = req[oth] ? oth : -1;
                else if (req[oth] && m_tenure >= MAX_BURST) nxt = oth;
                else                                     nxt = m_own;
            end
            if (nxt != m_own) begin
                m_tenure = 1;
                if (nxt >= 0) m_last = nxt;
            end else begin
                m_tenure++;
            end
            m_own = nxt;
        end
    endtask

    initial begin
        chk_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < (1 << (ADDR_LEN + SEL_LEN)); i++) begin
            mem_arr[i] = '0;
            m_mem[i]   = '0;
        end
        bus.r0_req = 0; bus.r0_addr = '0; bus.r0_sel = '0; bus.r0_wq = 0; bus.r0_wdata = '0;
        bus.r1_req = 0; bus.r1_addr = '0; bus.r1_sel = '0; bus.r1_wq = 0; bus.r1_wdata = '0;
        rst = 1'b1;
        m_rd = '0;
        model_reset();
        repeat (2) @(posedge clk);

        for (int c = 0; c < N_CYCLES; c++)
            one_cycle();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
